// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-port arbiter state encoding and the lw/sw opcodes
// also decoded by the hazard/decode logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } arb_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OP_LOAD) || (opcode == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side requests and the shared memory port, grouped for the arbiter.
// The arbiter owns the slave view; the pipeline/memory environment owns the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic              err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata, m_ack,
    output if_rdata, mem_rdata, done, m_req, m_we, m_addr, m_wdata, err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, m_rdata, m_ack,
    input  if_rdata, mem_rdata, done, m_req, m_we, m_addr, m_wdata, err
  );

endinterface

// File: rtl/ack_watchdog.sv
// Counts cycles an access waits for its ack; expire fires combinationally on the cycle
// the count would reach TIMEOUT. No backpressure: clr wins over en.
module ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises one data access then one fetch per pipeline step onto a single memory port;
// fetch-only step takes L+2 cycles, data+fetch 2L+3; done=0 freezes the pipeline meanwhile.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              err_q, err_d;
  logic              done_c;
  logic              ack_ok;
  logic              wd_clr;
  logic              expire;

  // An ack only counts while a request is actually outstanding.
  assign ack_ok = m_req_q && bus.m_ack;

  ack_watchdog #(.TIMEOUT(TIMEOUT)) u_ack_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wd_clr),
    .en     (m_req_q && !bus.m_ack),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    err_d       = err_q;
    wd_clr      = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        done_c = !bus.if_req && !bus.mem_req;
        if (bus.mem_req) begin
          m_req_d   = 1'b1;
          m_we_d    = bus.mem_we;
          m_addr_d  = bus.mem_addr;
          m_wdata_d = bus.mem_wdata;
          wd_clr    = 1'b1;
          state_d   = S_DATA;
        end else if (bus.if_req) begin
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = bus.if_addr;
          wd_clr   = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_DATA: begin
        if (ack_ok) begin
          m_req_d = 1'b0;
          if (!m_we_q) begin
            mem_rdata_d = bus.m_rdata;
          end
          state_d = bus.if_req ? S_DATA : S_DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          m_req_d = 1'b0;
          state_d = S_DONE;
        end else if (!m_req_q) begin
          // Idle gap after the data ack: re-issue the port as the fetch.
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = bus.if_addr;
          wd_clr   = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        if (ack_ok) begin
          if_rdata_d = bus.m_rdata;
          m_req_d    = 1'b0;
          state_d    = S_DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          m_req_d = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.done      = rstn && done_c;
  assign bus.m_req     = m_req_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable memory responder plus
// hand-computed per-step expectations (cycle counts, issued addresses, captured data).
module tb_mem_port_arbiter;

  logic clk;
  logic rstn;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0030_0093;
      32'h0000_0014: return 32'h0040_0113;
      32'h0000_0018: return 32'h0050_0193;
      32'h0000_2000: return 32'h1234_5678;
      default:       return 32'hBAD0_0000 | a;
    endcase
  endfunction

  // Memory responder: acks on the lat-th cycle m_req is seen high.
  int   lat = 2;
  logic ack_en = 1'b1;
  logic spur_ack = 1'b0;
  int   rcnt = 0;

  initial begin
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_req && rstn) rcnt++;
      else rcnt = 0;
      bus.m_ack   = spur_ack || (ack_en && bus.m_req && (rcnt == lat));
      bus.m_rdata = spur_ack ? 32'hFFFF_FFFF : (bus.m_ack ? rd_val(bus.m_addr) : 32'h0);
    end
  end

  logic [31:0] iss_addr [4];
  logic [31:0] iss_wdata[4];
  logic        iss_we   [4];
  int          n_iss;

  // Called in the IDLE cycle carrying the step's requests (cycle 1); returns at the
  // negedge of the done cycle.
  task automatic run_step(output int ncyc, output int nreq);
    logic prev;
    int   c;
    ncyc  = 0;
    nreq  = 0;
    n_iss = 0;
    prev  = bus.m_req;
    c     = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      c++;
      if (bus.m_req) nreq++;
      if (bus.m_req && !prev && n_iss < 4) begin
        iss_addr[n_iss]  = bus.m_addr;
        iss_wdata[n_iss] = bus.m_wdata;
        iss_we[n_iss]    = bus.m_we;
        n_iss++;
      end
      prev = bus.m_req;
      if (bus.done) begin
        ncyc = c;
        break;
      end
    end
    if (ncyc == 0) check("step_bound_expired", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=stalled expected=finish");
    $fatal(1);
  end

  int nc, nr;

  initial begin
    rstn          = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_done",      32'(bus.done), 32'd0);
    check("rst_m_req",     32'(bus.m_req), 32'd0);
    check("rst_m_we",      32'(bus.m_we), 32'd0);
    check("rst_m_addr",    bus.m_addr, 32'h0);
    check("rst_m_wdata",   bus.m_wdata, 32'h0);
    check("rst_if_rdata",  bus.if_rdata, 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    check("rst_err",       32'(bus.err), 32'd0);

    rstn = 1'b1;
    @(negedge clk); #1;
    check("idle_done", 32'(bus.done), 32'd1);
    check("idle_m_req", 32'(bus.m_req), 32'd0);

    // Spurious ack in IDLE must not touch any register.
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("spur_if_rdata",  bus.if_rdata, 32'h0);
    check("spur_mem_rdata", bus.mem_rdata, 32'h0);
    check("spur_m_req",     32'(bus.m_req), 32'd0);
    check("spur_done",      32'(bus.done), 32'd1);

    // Fetch only, latency 2.
    lat = 2;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    check("fetch_idle_done", 32'(bus.done), 32'd0);
    run_step(nc, nr);
    check("fetch_cycles",   32'(nc), 32'd4);
    check("fetch_req_cyc",  32'(nr), 32'd2);
    check("fetch_issues",   32'(n_iss), 32'd1);
    check("fetch_addr",     iss_addr[0], 32'h10);
    check("fetch_we",       32'(iss_we[0]), 32'd0);
    check("fetch_if_rdata", bus.if_rdata, 32'h0030_0093);
    check("fetch_m_req_off", 32'(bus.m_req), 32'd0);

    // Load + fetch, latency 1, requested straight after the previous done.
    lat = 1;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h2000;
    bus.if_addr  = 32'h14;
    @(negedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    run_step(nc, nr);
    check("ld_cycles",    32'(nc), 32'd5);
    check("ld_req_cyc",   32'(nr), 32'd2);
    check("ld_issues",    32'(n_iss), 32'd2);
    check("ld_addr0",     iss_addr[0], 32'h2000);
    check("ld_we0",       32'(iss_we[0]), 32'd0);
    check("ld_addr1",     iss_addr[1], 32'h14);
    check("ld_mem_rdata", bus.mem_rdata, 32'h1234_5678);
    check("ld_if_rdata",  bus.if_rdata, 32'h0040_0113);

    // Store + fetch: mem_rdata must keep the load value.
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h3000;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.if_addr   = 32'h18;
    @(negedge clk);
    run_step(nc, nr);
    check("st_cycles",    32'(nc), 32'd5);
    check("st_issues",    32'(n_iss), 32'd2);
    check("st_addr0",     iss_addr[0], 32'h3000);
    check("st_we0",       32'(iss_we[0]), 32'd1);
    check("st_wdata0",    iss_wdata[0], 32'hDEAD_BEEF);
    check("st_addr1",     iss_addr[1], 32'h18);
    check("st_we1",       32'(iss_we[1]), 32'd0);
    check("st_mem_rdata", bus.mem_rdata, 32'h1234_5678);
    check("st_if_rdata",  bus.if_rdata, 32'h0050_0193);

    // Fetch with no ack ever: times out after 4 request cycles.
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.if_addr = 32'h1C;
    ack_en      = 1'b0;
    @(negedge clk);
    run_step(nc, nr);
    check("to_cycles",   32'(nc), 32'd6);
    check("to_req_cyc",  32'(nr), 32'd4);
    check("to_err",      32'(bus.err), 32'd1);
    check("to_m_req",    32'(bus.m_req), 32'd0);
    check("to_if_rdata", bus.if_rdata, 32'h0050_0193);

    // Next step completes normally while err stays set.
    ack_en      = 1'b1;
    lat         = 2;
    bus.if_addr = 32'h10;
    @(negedge clk);
    run_step(nc, nr);
    check("post_to_cycles",   32'(nc), 32'd4);
    check("post_to_err",      32'(bus.err), 32'd1);
    check("post_to_if_rdata", bus.if_rdata, 32'h0030_0093);
    bus.if_req = 1'b0;
    @(negedge clk); #1;
    check("post_to_idle_done", 32'(bus.done), 32'd1);
    check("err_sticky",        32'(bus.err), 32'd1);

    // Reset in the middle of a data access.
    lat          = 3;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h2000;
    @(negedge clk);
    check("mid_data_m_req", 32'(bus.m_req), 32'd1);
    #2;
    rstn        = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    check("async_m_req", 32'(bus.m_req), 32'd0);
    check("async_done",  32'(bus.done), 32'd0);
    @(negedge clk);
    check("rst2_err",       32'(bus.err), 32'd0);
    check("rst2_mem_rdata", bus.mem_rdata, 32'h0);
    rstn     = 1'b1;
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("late_ack_mem_rdata", bus.mem_rdata, 32'h0);
    check("late_ack_m_req",     32'(bus.m_req), 32'd0);
    check("late_ack_done",      32'(bus.done), 32'd1);

    // Port still usable after the abandoned access.
    lat         = 1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h14;
    run_step(nc, nr);
    check("final_cycles",   32'(nc), 32'd3);
    check("final_if_rdata", bus.if_rdata, 32'h0040_0113);
    bus.if_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
